// File: rtl/display_scan_ctrl_pkg.sv
// display_scan_ctrl_pkg: shared FSM states and segment constants for the display scanner
package display_scan_ctrl_pkg;

    typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Active-low {a,b,c,d,e,f,g} patterns, entry 15 (F) first down to entry 0
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'b0111000, 7'b0110000, 7'b1000010, 7'b0110001,
        7'b1100000, 7'b0001000, 7'b0000100, 7'b0000000,
        7'b0001111, 7'b0100000, 7'b0100100, 7'b1001100,
        7'b0000110, 7'b0010010, 7'b1001111, 7'b0000001
    };

endpackage

// File: rtl/display_scan_ctrl_hex_to_7seg.sv
// hex_to_7seg: combinational hex nibble to active-low seven-segment pattern
module hex_to_7seg
    import display_scan_ctrl_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg_n
);

    assign seg_n = SEG_TABLE[nibble];

endmodule

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: tick-driven 7-segment scanner with blanking and frame-aligned double buffer
module display_scan_ctrl
    import display_scan_ctrl_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                    CLK,
    input  logic                    Reset,
    input  logic                    Enable,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    lz_suppress,
    input  logic                    load,
    output logic [6:0]              seg_n,
    output logic                    dp_n,
    output logic [NUM_DIGITS-1:0]   an_n,
    output logic                    frame_done,
    output logic                    overrun
);

    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [IW-1:0] LAST = IW'(NUM_DIGITS - 1);
    localparam logic [7:0] BLANK_LAST = 8'(BLANK_CYCLES - 1);

    state_t                  state, state_nx;
    logic [IW-1:0]           idx;
    logic [7:0]              cnt;
    logic [4*NUM_DIGITS-1:0] pend_digits, act_digits;
    logic [NUM_DIGITS-1:0]   pend_dp, act_dp;
    logic                    pend_lz, act_lz, pend_valid;
    logic [3:0]              nibble;
    logic [6:0]              dec_seg, seg_d;
    logic                    dp_d;
    logic [NUM_DIGITS-1:0]   an_d;
    logic                    drive_tick, boundary, lz_hit;

    assign drive_tick = state == DRIVE && Enable;
    assign boundary   = drive_tick && idx == LAST;
    assign nibble     = act_digits[4*idx +: 4];
    // A digit is a leading zero when it and everything above it is zero; digit 0 always shows
    assign lz_hit     = act_lz && idx != '0 && (act_digits >> (4*idx)) == '0;

    hex_to_7seg u_dec (
        .nibble (nibble),
        .seg_n  (dec_seg)
    );

    // State register
    always_ff @(posedge CLK) state <= Reset ? IDLE : state_nx;

    // Next state: wait for first tick, blank for BLANK_CYCLES, then drive until the next tick
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = Enable ? BLANK : IDLE;
            BLANK:   state_nx = cnt == BLANK_LAST ? DRIVE : BLANK;
            DRIVE:   state_nx = Enable ? BLANK : DRIVE;
            default: state_nx = IDLE;
        endcase
    end

    // Scan index, blanking counter, sticky overrun and the frame-end pulse
    always_ff @(posedge CLK) begin
        if (Reset) begin
            idx        <= '0;
            cnt        <= '0;
            overrun    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            if (state == IDLE && Enable) begin
                idx <= '0;
                cnt <= '0;
            end else if (state == BLANK) begin
                cnt <= cnt + 1'b1;
            end else if (drive_tick) begin
                idx <= boundary ? '0 : idx + 1'b1;
                cnt <= '0;
            end
            overrun    <= overrun | (state == BLANK && Enable);
            frame_done <= boundary;
        end
    end

    // Double buffer: pending takes every load, active only changes at a frame boundary
    always_ff @(posedge CLK) begin
        if (Reset) begin
            pend_digits <= '0;
            pend_dp     <= '0;
            pend_lz     <= 1'b0;
            pend_valid  <= 1'b0;
            act_digits  <= '0;
            act_dp      <= '0;
            act_lz      <= 1'b0;
        end else begin
            if (boundary && pend_valid) begin
                act_digits <= pend_digits;
                act_dp     <= pend_dp;
                act_lz     <= pend_lz;
            end
            if (load) begin
                pend_digits <= digits_in;
                pend_dp     <= dp_in;
                pend_lz     <= lz_suppress;
                pend_valid  <= 1'b1;
            end else if (boundary) begin
                pend_valid <= 1'b0;
            end
        end
    end

    // Pin values implied by the current state; everything is dark outside DRIVE
    always_comb begin
        seg_d = state == DRIVE && !lz_hit ? dec_seg : SEG_OFF;
        dp_d  = !(state == DRIVE && act_dp[idx]);
        an_d  = state == DRIVE ? ~(NUM_DIGITS'(1) << idx) : '1;
    end

    // Output registers keep the pins glitch-free, one cycle behind the state
    always_ff @(posedge CLK) begin
        if (Reset) begin
            seg_n <= SEG_OFF;
            dp_n  <= 1'b1;
            an_n  <= '1;
        end else begin
            seg_n <= seg_d;
            dp_n  <= dp_d;
            an_n  <= an_d;
        end
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb_display_scan_ctrl: directed scenarios plus random ticks/loads against a slot-level scan model
module tb_display_scan_ctrl;

    localparam int N = 4;
    localparam int B = 16;
    localparam int P = 40;
    localparam logic [6:0] TBL [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    logic          CLK, Reset, Enable, lz_suppress, load;
    logic [4*N-1:0] digits_in;
    logic [N-1:0]  dp_in;
    logic [6:0]    seg_n;
    logic          dp_n;
    logic [N-1:0]  an_n;
    logic          frame_done, overrun;

    int total = 0;
    int bad = 0;
    int fd_cnt = 0;

    display_scan_ctrl #(.NUM_DIGITS(N), .BLANK_CYCLES(B)) dut (
        .CLK         (CLK),
        .Reset       (Reset),
        .Enable      (Enable),
        .digits_in   (digits_in),
        .dp_in       (dp_in),
        .lz_suppress (lz_suppress),
        .load        (load),
        .seg_n       (seg_n),
        .dp_n        (dp_n),
        .an_n        (an_n),
        .frame_done  (frame_done),
        .overrun     (overrun)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Model: a tick is accepted when idle or once the digit is lit; a digit lights B cycles after its tick
    bit          mvalid = 1'b0;
    bit          m_run, m_pv, m_ovr, m_alz, m_plz;
    int          m_since, m_slot;
    logic [15:0] m_adig, m_pdig;
    logic [3:0]  m_adp, m_pdp;
    logic [6:0]  e_seg;
    logic        e_dp, e_fd, e_ovr;
    logic [3:0]  e_an;

    function automatic bit suppressed(logic [15:0] d, bit lz, int i);
        if (!lz || i == 0) return 1'b0;
        for (int j = i; j < N; j++) if (d[4*j +: 4] != 4'h0) return 1'b0;
        return 1'b1;
    endfunction

    always @(posedge CLK) begin
        bit lit, acc;
        if (Reset) begin
            m_run = 0; m_since = 0; m_slot = 0; m_pv = 0; m_ovr = 0;
            m_adig = '0; m_adp = '0; m_alz = 0; m_pdig = '0; m_pdp = '0; m_plz = 0;
            e_seg = 7'h7F; e_dp = 1; e_an = 4'hF; e_fd = 0; e_ovr = 0;
            mvalid = 1;
        end else begin
            lit   = m_run && m_since >= B;
            e_an  = lit ? ~(4'b0001 << m_slot) : 4'hF;
            e_seg = (!lit || suppressed(m_adig, m_alz, m_slot)) ? 7'h7F : TBL[m_adig[4*m_slot +: 4]];
            e_dp  = !(lit && m_adp[m_slot]);
            e_fd  = 0;
            acc   = Enable && (!m_run || lit);
            if (acc && !m_run) begin
                m_run = 1; m_since = 0; m_slot = 0;
            end else if (acc) begin
                if (m_slot == N - 1) begin
                    e_fd = 1;
                    if (m_pv) begin
                        m_adig = m_pdig; m_adp = m_pdp; m_alz = m_plz; m_pv = 0;
                    end
                end
                m_slot  = (m_slot + 1) % N;
                m_since = 0;
            end else if (m_run) begin
                if (Enable) m_ovr = 1;
                m_since++;
            end
            if (load) begin
                m_pdig = digits_in; m_pdp = dp_in; m_plz = lz_suppress; m_pv = 1;
            end
            e_ovr = m_ovr;
        end
    end

    // Every-cycle comparison of all outputs against the model
    always @(negedge CLK) begin
        if (mvalid) begin
            total++;
            if ({seg_n, dp_n, an_n, frame_done, overrun} !== {e_seg, e_dp, e_an, e_fd, e_ovr}) begin
                bad++;
                $display("FAIL cycle t=%0t got seg=%b dp=%b an=%b fd=%b ovr=%b want seg=%b dp=%b an=%b fd=%b ovr=%b",
                         $time, seg_n, dp_n, an_n, frame_done, overrun, e_seg, e_dp, e_an, e_fd, e_ovr);
            end
            if (frame_done === 1'b1) fd_cnt++;
        end
    end

    task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, got, exp);
        end
    endtask

    task automatic run(int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic tick();
        Enable = 1'b1;
        @(negedge CLK);
        Enable = 1'b0;
    endtask

    task automatic do_load(logic [15:0] d, logic [3:0] dp, logic lz);
        digits_in = d; dp_in = dp; lz_suppress = lz; load = 1'b1;
        @(negedge CLK);
        load = 1'b0;
    endtask

    // One full digit slot of P cycles; checks the lit digit mid-slot
    task automatic slot_chk(string nm, logic [3:0] ean, logic [6:0] eseg, logic edp, bit ld = 1'b0);
        Enable = 1'b1; load = ld;
        @(negedge CLK);
        Enable = 1'b0; load = 1'b0;
        run(B + 2);
        chk(nm, {seg_n, dp_n, an_n}, {eseg, edp, ean});
        run(P - B - 3);
    endtask

    initial begin
        Reset = 1; Enable = 0; load = 0; digits_in = '0; dp_in = '0; lz_suppress = 0;
        run(3);
        chk("reset_out", {seg_n, dp_n, an_n, frame_done, overrun}, {7'h7F, 1'b1, 4'hF, 1'b0, 1'b0});
        Reset = 0;
        run(10);
        chk("idle_dark", {seg_n, dp_n, an_n}, {7'h7F, 1'b1, 4'hF});
        tick();
        run(B);
        chk("still_blank", an_n, 4'hF);
        run(2);
        chk("first_digit", {seg_n, dp_n, an_n}, {7'b0000001, 1'b1, 4'b1110});
        run(P - B - 3);
        slot_chk("second_digit", 4'b1101, 7'b0000001, 1'b1);
        slot_chk("d2_zero", 4'b1011, 7'b0000001, 1'b1);
        slot_chk("d3_zero", 4'b0111, 7'b0000001, 1'b1);
        chk("fd_none", fd_cnt, 0);

        do_load(16'h12AF, 4'b0100, 1'b0);
        slot_chk("hex_d0_F", 4'b1110, 7'b0111000, 1'b1);
        slot_chk("hex_d1_A", 4'b1101, 7'b0001000, 1'b1);
        slot_chk("hex_d2_2dp", 4'b1011, 7'b0010010, 1'b0);
        slot_chk("hex_d3_1", 4'b0111, 7'b1001111, 1'b1);
        chk("fd_one", fd_cnt, 1);

        do_load(16'h0007, 4'b1000, 1'b1);
        slot_chk("lz_d0_7", 4'b1110, 7'b0001111, 1'b1);
        slot_chk("lz_d1", 4'b1101, 7'h7F, 1'b1);
        slot_chk("lz_d2", 4'b1011, 7'h7F, 1'b1);
        slot_chk("lz_d3_dp", 4'b0111, 7'h7F, 1'b0);
        do_load(16'h0007, 4'b0000, 1'b0);
        slot_chk("nolz_d0", 4'b1110, 7'b0001111, 1'b1);
        slot_chk("nolz_d1", 4'b1101, 7'b0000001, 1'b1);
        slot_chk("nolz_d2", 4'b1011, 7'b0000001, 1'b1);
        slot_chk("nolz_d3", 4'b0111, 7'b0000001, 1'b1);
        chk("fd_three", fd_cnt, 3);

        slot_chk("mid_d0", 4'b1110, 7'b0001111, 1'b1);
        do_load(16'h1111, 4'b0000, 1'b0);
        slot_chk("mid_d1_old", 4'b1101, 7'b0000001, 1'b1);
        do_load(16'h2222, 4'b0000, 1'b0);
        slot_chk("mid_d2_old", 4'b1011, 7'b0000001, 1'b1);
        slot_chk("mid_d3_old", 4'b0111, 7'b0000001, 1'b1);
        slot_chk("two_d0", 4'b1110, 7'b0010010, 1'b1);
        slot_chk("two_d1", 4'b1101, 7'b0010010, 1'b1);
        do_load(16'h4444, 4'b0000, 1'b0);
        slot_chk("two_d2", 4'b1011, 7'b0010010, 1'b1);
        slot_chk("two_d3", 4'b0111, 7'b0010010, 1'b1);
        digits_in = 16'h3333; dp_in = 4'b0000; lz_suppress = 1'b0;
        slot_chk("bnd_d0_old", 4'b1110, 7'b1001100, 1'b1, 1'b1);
        slot_chk("bnd_d1_old", 4'b1101, 7'b1001100, 1'b1);
        slot_chk("bnd_d2_old", 4'b1011, 7'b1001100, 1'b1);
        slot_chk("bnd_d3_old", 4'b0111, 7'b1001100, 1'b1);
        slot_chk("late_d0", 4'b1110, 7'b0000110, 1'b1);
        slot_chk("late_d3x", 4'b1101, 7'b0000110, 1'b1);
        chk("fd_seven", fd_cnt, 7);

        Reset = 1; run(2); Reset = 0;
        slot_chk("ovr_pre", 4'b1110, 7'b0000001, 1'b1);
        tick();
        run(4);
        tick();
        run(B);
        chk("ovr_set", overrun, 1);
        chk("ovr_idx_kept", an_n, 4'b1101);
        run(P);
        chk("ovr_sticky", overrun, 1);
        Reset = 1; run(2); Reset = 0;
        chk("ovr_clr", overrun, 0);

        slot_chk("r_d0", 4'b1110, 7'b0000001, 1'b1);
        slot_chk("r_d1", 4'b1101, 7'b0000001, 1'b1);
        tick();
        run(B + 2);
        chk("pre_rst_d2", an_n, 4'b1011);
        Reset = 1;
        @(negedge CLK);
        chk("rst_mid", {seg_n, dp_n, an_n, frame_done}, {7'h7F, 1'b1, 4'hF, 1'b0});
        Reset = 0;
        run(3);
        slot_chk("restart_d0", 4'b1110, 7'b0000001, 1'b1);

        for (int c = 0; c < 20000; c++) begin
            Enable = $urandom_range(0, 29) == 0;
            load = $urandom_range(0, 39) == 0;
            if (load) begin
                for (int k = 0; k < N; k++)
                    digits_in[4*k +: 4] = $urandom_range(0, 1) ? 4'h0 : 4'($urandom_range(0, 15));
                dp_in = 4'($urandom_range(0, 15));
                lz_suppress = 1'($urandom_range(0, 1));
            end
            Reset = $urandom_range(0, 2999) == 0;
            @(negedge CLK);
        end
        Enable = 0; load = 0; Reset = 0;
        run(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
